// File: rtl/strb_debounce.sv
// strb_debounce: multi-channel debouncer for slow mechanical inputs.
// Each raw input is double-flopped into the clock domain. On strobe cycles it is
// compared against the channel's debounced level. A channel flips only after STABLE
// consecutive strobe samples disagree with its current level. Each flip produces a
// one-clock rise or fall pulse that is aligned with the first cycle of the new level.
module strb_debounce #(
  parameter int CH     = 4,
  parameter int STABLE = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          strb_i,
  input  logic [CH-1:0] raw_i,
  output logic [CH-1:0] state_o,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] fall_o
);

  // Wide enough to hold 0..STABLE. The counter itself never exceeds STABLE-1.
  localparam int CW = $clog2(STABLE + 1);

  // Terminal count. When a disagreeing sample arrives at this count, the channel flips.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  // Per-channel update result for one strobe sample.
  typedef struct packed {
    logic          state;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fall;
  } chan_upd_t;

  // Two-stage synchronizer flops. s2_q is the only value the debouncer looks at.
  logic [CH-1:0]         s1_q, s1_d;
  logic [CH-1:0]         s2_q, s2_d;

  // Debounced level, per-channel disagreement counters and registered edge pulses.
  logic [CH-1:0]         state_q, state_d;
  logic [CH-1:0][CW-1:0] cnt_q,   cnt_d;
  logic [CH-1:0]         rise_q,  rise_d;
  logic [CH-1:0]         fall_q,  fall_d;

  // One strobe sample of one channel.
  // An agreeing sample cancels any pending flip. A disagreeing sample either
  // advances the run or, on the STABLE-th consecutive disagreement, flips the level.
  function automatic chan_upd_t chan_step(input logic          samp,
                                          input logic          cur,
                                          input logic [CW-1:0] cnt);
    chan_upd_t r;
    r.state = cur;
    r.cnt   = '0;
    r.rise  = 1'b0;
    r.fall  = 1'b0;
    if (samp != cur) begin
      if (cnt == CNT_LAST) begin
        r.state = ~cur;
        r.cnt   = '0;
        r.rise  = samp;
        r.fall  = ~samp;
      end else begin
        r.cnt = cnt + CW'(1);
      end
    end
    return r;
  endfunction

  // Synchronizer shifts every clock, independent of the strobe.
  always_comb begin
    s1_d = raw_i;
    s2_d = s1_q;
  end

  // Debounce update. Level and counters hold between strobes; the pulses clear.
  always_comb begin
    chan_upd_t upd;
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    upd     = '0;
    if (strb_i) begin
      for (int c = 0; c < CH; c++) begin
        upd        = chan_step(s2_q[c], state_q[c], cnt_q[c]);
        state_d[c] = upd.state;
        cnt_d[c]   = upd.cnt;
        rise_d[c]  = upd.rise;
        fall_d[c]  = upd.fall;
      end
    end
  end

  // State registers. Reset clears everything, synchronizer included, so that a
  // held input must be re-synchronized and fully re-qualified after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    state_o = state_q;
    rise_o  = rise_q;
    fall_o  = fall_q;
  end

endmodule

// File: tb/tb_strb_debounce.sv
// Scoreboard bench for strb_debounce.
// A behavioural model runs at each clock edge and pushes the expected outputs.
// A negedge monitor pops each expectation and compares it with the DUT outputs.
module tb_strb_debounce;
  localparam int CH     = 4;
  localparam int STABLE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          strb = 1'b0;
  logic [CH-1:0] raw = '1;
  logic [CH-1:0] state, rise, fall;

  always #5 clk = ~clk;

  strb_debounce #(.CH(CH), .STABLE(STABLE)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .strb_i (strb),
    .raw_i  (raw),
    .state_o(state),
    .rise_o (rise),
    .fall_o (fall)
  );

  typedef struct packed {
    logic [CH-1:0] st;
    logic [CH-1:0] ri;
    logic [CH-1:0] fa;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad   = 0;
  int            mode  = 0;   // 0: strobe every 8 clk, 1: held high, 2: random
  int            m_rise_cnt[CH];
  int            d_rise_cnt[CH];

  // Reference model.
  // The input reaches the sampler two edges late.
  // Each channel counts consecutive disagreeing strobe samples.
  initial begin
    logic [CH-1:0] dly[2];
    logic [CH-1:0] lvl;
    int            run[CH];
    logic [CH-1:0] samp, r_e, f_e;
    exp_t          e;
    dly[0] = '0;
    dly[1] = '0;
    lvl    = '0;
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      m_rise_cnt[c] = 0;
    end
    forever begin
      @(posedge clk);
      samp = dly[0];
      r_e  = '0;
      f_e  = '0;
      if (rst) begin
        dly[0] = '0;
        dly[1] = '0;
        lvl    = '0;
        for (int c = 0; c < CH; c++) run[c] = 0;
      end else begin
        dly[0] = dly[1];
        dly[1] = raw;
        if (strb) begin
          for (int c = 0; c < CH; c++) begin
            if (samp[c] != lvl[c]) begin
              run[c] = run[c] + 1;
              if (run[c] == STABLE) begin
                run[c] = 0;
                lvl[c] = samp[c];
                if (samp[c]) begin
                  r_e[c] = 1'b1;
                  m_rise_cnt[c] = m_rise_cnt[c] + 1;
                end else begin
                  f_e[c] = 1'b1;
                end
              end
            end else begin
              run[c] = 0;
            end
          end
        end
      end
      e.st = lvl;
      e.ri = r_e;
      e.fa = f_e;
      sbq.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation, away from the active edge.
  initial begin
    exp_t e;
    for (int c = 0; c < CH; c++) d_rise_cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        total++;
        if ({state, rise, fall} !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got state=%b rise=%b fall=%b want state=%b rise=%b fall=%b",
                   $time, state, rise, fall, e.st, e.ri, e.fa);
        end
        for (int c = 0; c < CH; c++) if (rise[c] === 1'b1) d_rise_cnt[c]++;
      end
    end
  end

  // Strobe generator. It drives just after each posedge.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       begin strb = (ph == 7); ph = (ph + 1) % 8; end
        1:       strb = 1'b1;
        default: strb = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for n strobe edges, bounded so that a broken strobe source cannot hang the run.
  task automatic wait_strobes(input int n);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < n && guard < 1000) begin
      @(posedge clk);
      if (strb) k++;
      guard++;
    end
    #1;
    if (k < n) begin
      total++;
      bad++;
      $display("FAIL strobe_wait got=%0d strobes want=%0d", k, n);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    int found;
    // Reset held with all inputs high.
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    raw = '0;
    wait_clk(20);

    // Channel 0 rises and is held.
    raw[0] = 1'b1;
    wait_clk(60);
    check("ch0_level", 32'(state[0]), 32'd1);

    // Channel 1: a 3-sample glitch is rejected, then a 4-sample run is accepted.
    wait_strobes(1);
    raw[1] = 1'b1;
    wait_strobes(3);
    raw[1] = 1'b0;
    wait_clk(20);
    check("ch1_glitch", 32'(state[1]), 32'd0);
    raw[1] = 1'b1;
    wait_clk(60);
    check("ch1_level", 32'(state[1]), 32'd1);

    // Simultaneous flips on all channels.
    raw = 4'b0101;
    wait_clk(60);
    check("pattern_0101", 32'(state), 32'h5);
    raw = 4'b1010;
    wait_clk(60);
    check("pattern_1010", 32'(state), 32'hA);

    // Strobe held high: latency is exactly 2 + STABLE clocks.
    mode = 1;
    wait_clk(6);
    raw[2] = 1'b1;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (state[2] && found == 0) found = k;
    end
    check("held_strobe_latency", 32'(found), 32'(2 + STABLE));

    // Reset in the middle of a count discards the partial progress.
    mode = 0;
    raw = '0;
    wait_clk(60);
    raw[3] = 1'b1;
    wait_strobes(2);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(24);
    check("ch3_after_reset_early", 32'(state[3]), 32'd0);
    wait_clk(40);
    check("ch3_after_reset_late", 32'(state[3]), 32'd1);

    // Randomized inputs, strobes and occasional resets.
    mode = 2;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 15) == 0) raw[c] = ~raw[c];
      rst = ($urandom_range(0, 299) == 0);
      wait_clk(1);
    end
    rst = 1'b0;
    mode = 0;
    wait_clk(30);

    for (int c = 0; c < CH; c++) check($sformatf("rise_count_ch%0d", c), 32'(d_rise_cnt[c]), 32'(m_rise_cnt[c]));

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
